// File: rtl/temp_queue.sv
// ---------------------------------------------------------------------------
// temp_queue
//
// Purpose:
//   Multi-entry FIFO for temporary operands, such as buffered ALU results or
//   the intermediate values of multi-cycle operations.
//   - The write side follows the temp_in/reg_wr pairing used by temp_storage.
//   - The read side pops words in strict FIFO order into a registered
//     temp_out.
//   - Single clock domain.
//
// Ports:
//   clk         in   1        rising-edge clock
//   rst         in   1        synchronous active-high reset
//   temp_in     in   WIDTH    write data
//   reg_wr      in   1        write request
//   rd_en       in   1        read (pop) request
//   temp_out    out  WIDTH    registered read data
//   temp_valid  out  1        one-cycle pulse: temp_out holds a freshly popped word
//   full        out  1        DEPTH entries held
//   empty       out  1        no entries held
//   count       out  AW+1     number of entries held, 0..DEPTH
//   err         out  1        sticky error flag (only with TEMP_QUEUE_ERR_EN)
//
// Configuration macro:
//   TEMP_QUEUE_ERR_EN
//     When defined, adds the err port. err is set by a dropped write (a write
//     to a full queue with no accepted read) or by a rejected read (a read
//     of an empty queue). It stays set until reset.
//     When undefined, there is no err port and those events are silent.
// ---------------------------------------------------------------------------
module temp_queue #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] temp_in,
    input  logic             reg_wr,
    input  logic             rd_en,
    output logic [WIDTH-1:0] temp_out,
    output logic             temp_valid,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
`ifdef TEMP_QUEUE_ERR_EN
    ,
    output logic             err
`endif
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             rd_ok;
    logic             wr_ok;
    logic [AW:0]      count_next;

    // A read is accepted whenever the queue holds data.
    // A write to a full queue is still accepted if a read frees a slot on
    // the same edge.
    // An empty queue never bypasses the incoming word to the read side.
    always_comb begin
        rd_ok      = rd_en && !empty;
        wr_ok      = reg_wr && (!full || rd_ok);
        count_next = count;
        if (wr_ok && !rd_ok) begin
            count_next = count + (AW+1)'(1);
        end else if (rd_ok && !wr_ok) begin
            count_next = count - (AW+1)'(1);
        end
    end

    // Storage is deliberately left uncleared by reset.
    // Reset still blocks writes, because rst has priority over reg_wr.
    always_ff @(posedge clk) begin
        if (!rst && wr_ok) begin
            mem[wr_ptr] <= temp_in;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    // Flags are derived from the next count, so they describe the state
    // after the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            temp_out   <= '0;
            temp_valid <= 1'b0;
            empty      <= 1'b1;
            full       <= 1'b0;
        end else begin
            temp_valid <= rd_ok;
            if (rd_ok) begin
                temp_out <= mem[rd_ptr];
                rd_ptr   <= rd_ptr + AW'(1);
            end
            if (wr_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            count <= count_next;
            full  <= (count_next == DEPTH_C);
            empty <= (count_next == '0);
        end
    end

`ifdef TEMP_QUEUE_ERR_EN
    // err is sticky: any dropped write or rejected read sets it.
    // Only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if ((reg_wr && !wr_ok) || (rd_en && !rd_ok)) begin
            err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_temp_queue.sv
// ---------------------------------------------------------------------------
// tb_temp_queue
//
// Purpose:
//   Self-checking bench for temp_queue, using the default DEPTH=4 build.
//   - Stimulus: directed scenarios, then randomized traffic.
//   - Reference model: a plain SystemVerilog queue.
//   - Popped words are pushed to a scoreboard. A separate monitor compares
//     them whenever the DUT raises temp_valid.
//
// Ports: none (top-level bench).
// Configuration macro: TEMP_QUEUE_ERR_EN (when defined, err is also checked).
// ---------------------------------------------------------------------------
module tb_temp_queue;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] temp_in;
    logic             reg_wr;
    logic             rd_en;
    logic [WIDTH-1:0] temp_out;
    logic             temp_valid;
    logic             full;
    logic             empty;
    logic [AW:0]      count;
`ifdef TEMP_QUEUE_ERR_EN
    logic             err;
`endif

    temp_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .temp_in    (temp_in),
        .reg_wr     (reg_wr),
        .rd_en      (rd_en),
        .temp_out   (temp_out),
        .temp_valid (temp_valid),
        .full       (full),
        .empty      (empty),
        .count      (count)
`ifdef TEMP_QUEUE_ERR_EN
        ,
        .err        (err)
`endif
    );

    always #5 clk = ~clk;

    // Reference model state and the scoreboard of expected popped words.
    logic [WIDTH-1:0] model_q [$];
    logic [WIDTH-1:0] sb [$];
    logic [WIDTH-1:0] exp_out;
    logic             exp_valid;
    logic             exp_err;
    int               errors = 0;
    int               checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: each temp_valid pulse must match the oldest outstanding pop.
    always @(negedge clk) begin
        if (temp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_valid: got data %0h expected no pop at %0t", temp_out, $time);
            end else begin
                check("popped_data", 32'(temp_out), 32'(sb.pop_front()));
            end
        end
    end

    // Compare the registered status outputs against the model after an edge.
    task automatic check_output();
        check("count", 32'(count), 32'(model_q.size()));
        check("full", 32'(full), 32'(model_q.size() == DEPTH));
        check("empty", 32'(empty), 32'(model_q.size() == 0));
        check("temp_valid", 32'(temp_valid), 32'(exp_valid));
        check("temp_out", 32'(temp_out), 32'(exp_out));
`ifdef TEMP_QUEUE_ERR_EN
        check("err", 32'(err), 32'(exp_err));
`endif
    endtask

    // Drive one cycle of inputs.
    // At the rising edge, update the model the way the queue should behave.
    // Then check at the falling edge.
    task automatic apply_stimulus(input logic r, input logic w, input logic rd,
                                  input logic [WIDTH-1:0] d);
        logic rd_acc;
        logic wr_acc;
        rst     = r;
        reg_wr  = w;
        rd_en   = rd;
        temp_in = d;
        @(posedge clk);
        if (r) begin
            model_q.delete();
            exp_out   = '0;
            exp_valid = 1'b0;
            exp_err   = 1'b0;
        end else begin
            rd_acc = rd && (model_q.size() > 0);
            wr_acc = w && ((model_q.size() < DEPTH) || rd_acc);
            exp_valid = rd_acc;
            if (rd_acc) begin
                exp_out = model_q.pop_front();
                sb.push_back(exp_out);
            end
            if (wr_acc) model_q.push_back(d);
            if ((w && !wr_acc) || (rd && !rd_acc)) exp_err = 1'b1;
        end
        @(negedge clk);
        rst    = 1'b0;
        reg_wr = 1'b0;
        rd_en  = 1'b0;
        check_output();
    endtask

    initial begin
        rst       = 1'b1;
        reg_wr    = 1'b0;
        rd_en     = 1'b0;
        temp_in   = '0;
        exp_out   = '0;
        exp_valid = 1'b0;
        exp_err   = 1'b0;

        // Reset for two cycles.
        apply_stimulus(1, 0, 0, 16'h0);
        apply_stimulus(1, 0, 0, 16'h0);

        // Two writes, then two reads.
        apply_stimulus(0, 1, 0, 16'h33CC);
        apply_stimulus(0, 1, 0, 16'hCC33);
        apply_stimulus(0, 0, 1, 16'h0);
        apply_stimulus(0, 0, 1, 16'h0);
        apply_stimulus(0, 0, 0, 16'h0);

        // Overfill: the fifth write is dropped.
        for (int i = 1; i <= 5; i++) apply_stimulus(0, 1, 0, 16'(i));
        for (int i = 0; i < 4; i++) apply_stimulus(0, 0, 1, 16'h0);
        apply_stimulus(0, 0, 0, 16'h0);

        // Full queue with simultaneous read and write.
        for (int i = 0; i < 4; i++) apply_stimulus(0, 1, 0, 16'h0010 + 16'(i));
        apply_stimulus(0, 1, 1, 16'h00AA);
        for (int i = 0; i < 4; i++) apply_stimulus(0, 0, 1, 16'h0);

        // Empty queue with simultaneous read and write: no bypass.
        apply_stimulus(0, 1, 1, 16'h1234);
        apply_stimulus(0, 0, 1, 16'h0);

        // Reset mid-traffic, then write/read pairs that wrap the pointers.
        for (int i = 0; i < 3; i++) apply_stimulus(0, 1, 0, 16'h0100 + 16'(i));
        apply_stimulus(1, 0, 1, 16'h0);
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(0, 1, 0, 16'h0A00 + 16'(i));
            apply_stimulus(0, 0, 1, 16'h0);
        end

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            apply_stimulus(($urandom_range(0, 49) == 0), 1'($urandom),
                           1'($urandom), 16'($urandom));
        end

        // Drain: every expected pop must have been observed.
        apply_stimulus(0, 0, 0, 16'h0);
        apply_stimulus(0, 0, 0, 16'h0);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
